// File: rtl/uart_tx_line_arbiter.sv
// Round-robin arbiter sharing one UART TX byte path among N_REQ requesters.
// A grant is held for a whole message, through the byte flagged with i_req_last.
//
// Ports:
//   i_clk_20mhz, i_rst_20mhz     : clock, async active-low reset
//   i_req_data/valid/last        : per-requester byte stream (byte k at [8k+7:8k])
//   o_req_ready                  : byte of requester k consumed this cycle (comb)
//   o_tx_data/o_tx_valid         : write side of uart_tx_only (1-cycle strobe)
//   i_tx_ready                   : uart_tx_only FIFO can take a byte
//   o_grant, o_busy, o_timeout   : one-hot owner, FSM busy, stall revoke pulse
//
// Optional feature: define UART_TX_ARB_TIMEOUT_EN to revoke a grant whose owner
// stalls for TIMEOUT_CYCLES cycles inside a message.
module uart_tx_line_arbiter #(
  parameter int N_REQ          = 2,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic               i_clk_20mhz,
  input  logic               i_rst_20mhz,
  input  logic [8*N_REQ-1:0] i_req_data,
  input  logic [N_REQ-1:0]   i_req_valid,
  input  logic [N_REQ-1:0]   i_req_last,
  output logic [N_REQ-1:0]   o_req_ready,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic [N_REQ-1:0]   o_grant,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int IW = $clog2(N_REQ);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_line_arbiter: parameter out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARB,
    ST_XFER,
    ST_RELEASE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    rr_q, rr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [7:0]       txd_q, txd_d;
  logic             txv_q, txv_d;

  logic             any_valid;
  logic             win_found;
  logic [IW-1:0]    win_idx;
  logic             g_valid;
  logic             g_last;
  logic [7:0]       g_data;
  logic             accept;
  logic             stall_hit;

  assign any_valid = |i_req_valid;

  // Round-robin search: first requester above the pointer, then wrap to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && i_req_valid[k] && k > int'(rr_q)) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_found && i_req_valid[k] && k <= int'(rr_q)) begin
        win_found = 1'b1;
        win_idx   = IW'(k);
      end
    end
  end

  // Mux out the current owner's stream.
  always_comb begin
    g_valid = 1'b0;
    g_last  = 1'b0;
    g_data  = 8'h00;
    for (int k = 0; k < N_REQ; k++) begin
      if (gidx_q == IW'(k)) begin
        g_valid = i_req_valid[k];
        g_last  = i_req_last[k];
        g_data  = i_req_data[8*k +: 8];
      end
    end
  end

  assign accept = (state_q == ST_XFER) && g_valid && i_tx_ready;

  always_comb begin
    o_req_ready = '0;
    for (int k = 0; k < N_REQ; k++) begin
      o_req_ready[k] = (state_q == ST_XFER) && grant_q[k]
                       && i_req_valid[k] && i_tx_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gidx_d  = gidx_q;
    grant_d = grant_q;
    txd_d   = txd_q;
    txv_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (any_valid) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (win_found) begin
          gidx_d  = win_idx;
          grant_d = {{(N_REQ-1){1'b0}}, 1'b1} << win_idx;
          state_d = ST_XFER;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_XFER: begin
        if (accept) begin
          txv_d = 1'b1;
          txd_d = g_data;
          if (g_last) state_d = ST_RELEASE;
        end else if (stall_hit) begin
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        rr_d    = gidx_q;
        grant_d = '0;
        state_d = any_valid ? ST_ARB : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      state_q <= ST_IDLE;
      rr_q    <= IW'(N_REQ-1);
      gidx_q  <= '0;
      grant_q <= '0;
      txd_q   <= 8'h00;
      txv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gidx_q  <= gidx_d;
      grant_q <= grant_d;
      txd_q   <= txd_d;
      txv_q   <= txv_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES+1);

  logic [CW-1:0] stall_q, stall_d;
  logic          tmo_q, tmo_d;

  // Only owner silence counts; FIFO back-pressure holds the count.
  always_comb begin
    stall_d   = stall_q;
    tmo_d     = 1'b0;
    stall_hit = 1'b0;
    if (state_q == ST_XFER) begin
      if (accept) begin
        stall_d = '0;
      end else if (i_tx_ready && !g_valid) begin
        if (stall_q == CW'(TIMEOUT_CYCLES-1)) begin
          stall_hit = 1'b1;
          tmo_d     = 1'b1;
          stall_d   = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end
      end
    end else if (state_q == ST_RELEASE) begin
      stall_d = '0;
    end
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz) begin
    if (!i_rst_20mhz) begin
      stall_q <= '0;
      tmo_q   <= 1'b0;
    end else begin
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
    end
  end

  assign o_timeout = tmo_q;
`else
  assign stall_hit = 1'b0;
  assign o_timeout = 1'b0;
`endif

  assign o_grant    = grant_q;
  assign o_tx_data  = txd_q;
  assign o_tx_valid = txv_q;
  assign o_busy     = (state_q != ST_IDLE);

endmodule
